// File: rtl/cmp_pkg.sv
// ---------------------------------------------------------------------------
// cmp_pkg
//   Shared types and helpers for the sequential magnitude comparator.
//   cmp_state_t      : controller states (IDLE -> SCAN -> DONE -> IDLE)
//   cmp_res_t        : outcome recorded by the first differing slice
//   cascade_resolve(): maps the l/e/g cascade inputs to {lt, eq, gt}
//   res_flags()      : maps a recorded cmp_res_t to {lt, eq, gt}
// ---------------------------------------------------------------------------
package cmp_pkg;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} cmp_state_t;

    typedef enum logic [1:0] {R_NONE, R_LT, R_EQ, R_GT} cmp_res_t;

    // Priority e > g > l. With no cascade input set, the legacy 4-bit part
    // reported both lt and gt, and chained designs still rely on that.
    function automatic logic [2:0] cascade_resolve(input logic l_in,
                                                   input logic e_in,
                                                   input logic g_in);
        logic [2:0] flags;
        if (e_in)      flags = 3'b010;
        else if (g_in) flags = 3'b001;
        else if (l_in) flags = 3'b100;
        else           flags = 3'b101;
        return flags;
    endfunction

    function automatic logic [2:0] res_flags(input cmp_res_t res);
        logic [2:0] flags;
        case (res)
            R_LT:    flags = 3'b100;
            R_EQ:    flags = 3'b010;
            R_GT:    flags = 3'b001;
            default: flags = 3'b000;
        endcase
        return flags;
    endfunction

endpackage

// File: rtl/cmp_slice.sv
// ---------------------------------------------------------------------------
// cmp_slice
//   Combinational unsigned compare of one SLICE-bit digit.
//   x, y : digit operands
//   lt   : x < y,  eq : x == y,  gt : x > y  (exactly one is set)
// ---------------------------------------------------------------------------
module cmp_slice #(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] x,
    input  logic [SLICE-1:0] y,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    assign lt = (x < y);
    assign eq = (x == y);
    assign gt = (x > y);

endmodule

// File: rtl/seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// seq_magnitude_comparator
//   Multi-cycle magnitude comparator: scans WIDTH-bit operands MSB-first,
//   one SLICE-bit digit per clock, optionally stopping at the first digit
//   that differs. Signed or unsigned compare; l/e/g cascade inputs resolve
//   fully-equal operands so several units can be chained.
//
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready   input handshake; a, b, signed_mode, l_in/e_in/g_in
//                         are captured only when both are high
//   out_valid / out_ready output handshake; lt/eq/gt/cycles held while
//                         out_valid is high and out_ready is low
//   lt, eq, gt            result flags (all zero when out_valid is low)
//   cycles                number of slices scanned for this result
// ---------------------------------------------------------------------------
module seq_magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int SLICE      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [WIDTH-1:0]                  a,
    input  logic [WIDTH-1:0]                  b,
    input  logic                              signed_mode,
    input  logic                              l_in,
    input  logic                              e_in,
    input  logic                              g_in,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              lt,
    output logic                              eq,
    output logic                              gt,
    output logic [$clog2(WIDTH/SLICE+1)-1:0]  cycles
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW     = $clog2(NSLICE + 1);
    localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    generate
        if ((WIDTH % SLICE) != 0) begin : g_bad_width
            $error("seq_magnitude_comparator: WIDTH must be a multiple of SLICE");
        end
    endgenerate

    // ---------------- state and holding registers ----------------
    cmp_state_t        state_reg, state_next;
    logic [WIDTH-1:0]  a_reg, b_reg;
    logic              signed_reg, l_reg, e_reg, g_reg;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              decided_reg, decided_next;
    cmp_res_t          dec_res_reg, dec_res_next;
    logic [2:0]        flags_reg, flags_next;      // {lt, eq, gt}
    logic [CW-1:0]     cycles_reg, cycles_next;

    logic accept;
    assign accept = (state_reg == IDLE) && in_valid;

    // ---------------- slice selection ----------------
    logic [SLICE-1:0] a_sl [NSLICE];
    logic [SLICE-1:0] b_sl [NSLICE];

    genvar gi;
    generate
        for (gi = 0; gi < NSLICE; gi++) begin : g_split
            assign a_sl[gi] = a_reg[gi*SLICE +: SLICE];
            assign b_sl[gi] = b_reg[gi*SLICE +: SLICE];
        end
    endgenerate

    logic [SLICE-1:0] x_sl, y_sl;
    logic             sl_lt, sl_eq, sl_gt;

    // Flipping the sign bit of the top digit maps two's complement onto
    // offset binary, so the same unsigned digit compare serves both modes.
    always_comb begin
        x_sl = a_sl[idx_reg];
        y_sl = b_sl[idx_reg];
        if (signed_reg && (idx_reg == IW'(NSLICE - 1))) begin
            x_sl[SLICE-1] = ~x_sl[SLICE-1];
            y_sl[SLICE-1] = ~y_sl[SLICE-1];
        end
    end

    cmp_slice #(.SLICE(SLICE)) u_slice (
        .x  (x_sl),
        .y  (y_sl),
        .lt (sl_lt),
        .eq (sl_eq),
        .gt (sl_gt)
    );

    // Result if the scan ended on this cycle: an earlier decision wins,
    // then the current digit, then the cascade inputs.
    logic [2:0] final_flags;
    always_comb begin
        if (decided_reg)  final_flags = res_flags(dec_res_reg);
        else if (sl_gt)   final_flags = 3'b001;
        else if (sl_lt)   final_flags = 3'b100;
        else              final_flags = cascade_resolve(l_reg, e_reg, g_reg);
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        cnt_next     = cnt_reg;
        decided_next = decided_reg;
        dec_res_next = dec_res_reg;
        flags_next   = flags_reg;
        cycles_next  = cycles_reg;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    state_next   = SCAN;
                    idx_next     = IW'(NSLICE - 1);
                    cnt_next     = '0;
                    decided_next = 1'b0;
                    dec_res_next = R_NONE;
                end
            end
            SCAN: begin
                cnt_next = cnt_reg + 1'b1;
                if (!decided_reg && !sl_eq) begin
                    decided_next = 1'b1;
                    dec_res_next = sl_gt ? R_GT : R_LT;
                end
                if (((EARLY_EXIT != 0) && !sl_eq) || (idx_reg == '0)) begin
                    state_next  = DONE;
                    flags_next  = final_flags;
                    cycles_next = cnt_reg + 1'b1;
                end else begin
                    idx_next = idx_reg - 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next  = IDLE;
                    flags_next  = 3'b000;
                    cycles_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            idx_reg     <= '0;
            cnt_reg     <= '0;
            decided_reg <= 1'b0;
            dec_res_reg <= R_NONE;
            flags_reg   <= 3'b000;
            cycles_reg  <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            signed_reg  <= 1'b0;
            l_reg       <= 1'b0;
            e_reg       <= 1'b0;
            g_reg       <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            cnt_reg     <= cnt_next;
            decided_reg <= decided_next;
            dec_res_reg <= dec_res_next;
            flags_reg   <= flags_next;
            cycles_reg  <= cycles_next;
            if (accept) begin
                a_reg      <= a;
                b_reg      <= b;
                signed_reg <= signed_mode;
                l_reg      <= l_in;
                e_reg      <= e_in;
                g_reg      <= g_in;
            end
        end
    end

    // ---------------- outputs ----------------
    // in_ready is qualified with rst_n so nothing is offered while held in reset.
    assign in_ready  = rst_n && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign lt        = flags_reg[2];
    assign eq        = flags_reg[1];
    assign gt        = flags_reg[0];
    assign cycles    = cycles_reg;

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// ---------------------------------------------------------------------------
// tb_seq_magnitude_comparator
//   Directed vectors against two comparators (WIDTH=16, SLICE=4): one with
//   early exit, one that always scans every slice. Expected flags are
//   written as {lt, eq, gt}.
// ---------------------------------------------------------------------------
module tb_seq_magnitude_comparator;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, in_valid_ne = 1'b0;
    logic        in_ready, in_ready_ne;
    logic [15:0] a = '0, b = '0;
    logic        signed_mode = 1'b0;
    logic        l_in = 1'b0, e_in = 1'b0, g_in = 1'b0;
    logic        out_valid, out_valid_ne;
    logic        out_ready = 1'b1, out_ready_ne = 1'b1;
    logic        lt, eq, gt, lt_ne, eq_ne, gt_ne;
    logic [2:0]  cycles, cycles_ne;

    int pass_cnt  = 0;
    int check_cnt = 0;

    always #5 clk = ~clk;

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .signed_mode(signed_mode),
        .l_in(l_in), .e_in(e_in), .g_in(g_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .lt(lt), .eq(eq), .gt(gt), .cycles(cycles)
    );

    seq_magnitude_comparator #(.WIDTH(16), .SLICE(4), .EARLY_EXIT(0)) dut_ne (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_ne), .in_ready(in_ready_ne),
        .a(a), .b(b), .signed_mode(signed_mode),
        .l_in(l_in), .e_in(e_in), .g_in(g_in),
        .out_valid(out_valid_ne), .out_ready(out_ready_ne),
        .lt(lt_ne), .eq(eq_ne), .gt(gt_ne), .cycles(cycles_ne)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        else
            pass_cnt++;
    endtask

    // Called just after a negedge with the unit idle. Leaves the bench at a
    // negedge one cycle after the result was sampled.
    task automatic run_op(input string tag, input bit ne,
                          input logic [15:0] ai, input logic [15:0] bi,
                          input logic s, input logic li, input logic ei, input logic gi,
                          input logic [2:0] exp_flags, input int exp_cyc);
        int lat;
        logic ov;
        logic [2:0] fl;
        logic [2:0] cy;
        a = ai; b = bi; signed_mode = s; l_in = li; e_in = ei; g_in = gi;
        if (ne) in_valid_ne = 1'b1; else in_valid = 1'b1;
        check({tag, ".in_ready"}, ne ? in_ready_ne : in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; in_valid_ne = 1'b0;
        // Scramble inputs: the unit must be working from its captured copy.
        a = ~ai; b = ~bi; signed_mode = ~s; l_in = ~li; e_in = ~ei; g_in = ~gi;
        lat = 0;
        ov  = ne ? out_valid_ne : out_valid;
        while (!ov && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ov = ne ? out_valid_ne : out_valid;
        end
        fl = ne ? {lt_ne, eq_ne, gt_ne} : {lt, eq, gt};
        cy = ne ? cycles_ne : cycles;
        check({tag, ".out_valid"}, ov, 1);
        check({tag, ".latency"}, lat, exp_cyc);
        check({tag, ".flags"}, fl, exp_flags);
        check({tag, ".cycles"}, cy, exp_cyc);
        $display("op %s: a=%h b=%h s=%0b lge=%0b%0b%0b -> lt/eq/gt=%03b cycles=%0d latency=%0d",
                 tag, ai, bi, s, li, ei, gi, fl, cy, lat);
        @(negedge clk);
    endtask

    initial begin
        int seen_ov;

        // Reset state
        #2;
        check("rst.in_ready", in_ready, 0);
        check("rst.out_valid", out_valid, 0);
        check("rst.flags", {lt, eq, gt}, 3'b000);
        check("rst.cycles", cycles, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle.in_ready", in_ready, 1);

        // 1: equal operands, cascade eq
        run_op("eq_casc",   0, 16'h1234, 16'h1234, 0, 0, 1, 0, 3'b010, 4);
        // 2: top digit differs, unsigned
        run_op("gt_u",      0, 16'h9000, 16'h1000, 0, 0, 0, 0, 3'b001, 1);
        run_op("gt_u_ne",   1, 16'h9000, 16'h1000, 0, 0, 0, 0, 3'b001, 4);
        // later digit must not override the first decision
        run_op("lt_u_ne",   1, 16'h1F00, 16'h2000, 0, 0, 0, 0, 3'b100, 4);
        // second digit decides
        run_op("lt_mid",    0, 16'h1200, 16'h1300, 0, 0, 0, 0, 3'b100, 2);
        // 3: signed
        run_op("lt_s",      0, 16'h9000, 16'h1000, 1, 0, 0, 0, 3'b100, 1);
        run_op("lt_s_m1",   0, 16'hFFFF, 16'h0000, 1, 0, 0, 0, 3'b100, 1);
        // 4: cascade priority
        run_op("casc_none", 0, 16'hABCD, 16'hABCD, 0, 0, 0, 0, 3'b101, 4);
        run_op("casc_g",    0, 16'hABCD, 16'hABCD, 0, 0, 0, 1, 3'b001, 4);
        run_op("casc_lg",   0, 16'hABCD, 16'hABCD, 0, 1, 0, 1, 3'b001, 4);
        run_op("casc_l",    0, 16'hABCD, 16'hABCD, 0, 1, 0, 0, 3'b100, 4);

        // 5: back-pressure in DONE
        out_ready = 1'b0;
        run_op("hold", 0, 16'h9000, 16'h1000, 0, 0, 0, 0, 3'b001, 1);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("hold.out_valid", out_valid, 1);
            check("hold.flags", {lt, eq, gt}, 3'b001);
            check("hold.cycles", cycles, 1);
            check("hold.in_ready", in_ready, 0);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release.out_valid", out_valid, 0);
        check("release.flags", {lt, eq, gt}, 3'b000);
        run_op("after_hold", 0, 16'h0005, 16'h0003, 0, 0, 0, 0, 3'b001, 4);

        // 6: reset pulse during SCAN
        a = 16'h1234; b = 16'h1234; e_in = 1'b1; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_scan.out_valid", out_valid, 0);
        check("rst_scan.flags", {lt, eq, gt}, 3'b000);
        check("rst_scan.cycles", cycles, 0);
        check("rst_scan.in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_ov = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen_ov++;
        end
        check("rst_scan.no_result", seen_ov, 0);
        run_op("post_rst", 0, 16'h0001, 16'h0002, 0, 0, 0, 0, 3'b100, 4);

        // Reset while a result is held in DONE clears it immediately
        out_ready = 1'b0;
        run_op("rst_done", 0, 16'h0001, 16'h0002, 0, 0, 0, 0, 3'b100, 4);
        rst_n = 1'b0;
        #1;
        check("rst_done.out_valid", out_valid, 0);
        check("rst_done.flags", {lt, eq, gt}, 3'b000);
        check("rst_done.cycles", cycles, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("rst_done.in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
